mode_button_ctrl: RTL and testbench

- Generates the 2-bit `mode` that the LED animation top consumes.
- Takes one raw, bouncy, active-low push button and synchronizes, debounces and classifies presses.
- Short press: advance to the next animation mode.
- Long press: force mode 3 (LEDs off); the next short press restarts at mode 0.

---
 rtl/led_anim_pkg.sv | 29 ++
 rtl/mode_button_ctrl_if.sv | 25 ++
 rtl/btn_debounce.sv | 47 ++++
 rtl/mode_button_ctrl.sv | 112 +++++++++++
 tb/tb_mode_button_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/led_anim_pkg.sv
// Shared definitions for the LED animation block: mode encodings, the
// button classifier state enum and the short-press mode step.
package led_anim_pkg;

   localparam int unsigned MODE_W = 2;

   localparam logic [MODE_W-1:0] MODE_SHIFT  = 2'd0;
   localparam logic [MODE_W-1:0] MODE_FILL   = 2'd1;
   localparam logic [MODE_W-1:0] MODE_BREATH = 2'd2;
   localparam logic [MODE_W-1:0] MODE_OFF    = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_HELD      = 2'd1,
      ST_LONG_HELD = 2'd2
   } btn_state_e;

   // Mode reached by a short press: OFF restarts at 0, last mode wraps to 0.
   function automatic logic [MODE_W-1:0] next_short_mode(
      input logic [MODE_W-1:0] cur,
      input int unsigned       num_modes
   );
      if (cur == MODE_OFF || cur == MODE_W'(num_modes - 1)) begin
         return MODE_SHIFT;
      end
      return cur + MODE_W'(1);
   endfunction

endpackage

// File: rtl/mode_button_ctrl_if.sv
// Button/mode bundle between the LED top (master) and mode_button_ctrl (slave).
//   btn_n        : raw active-low button
//   mode         : current animation mode
//   mode_changed : one-cycle pulse on every mode update
//   long_press   : one-cycle pulse when a long press is recognised
//   btn_db       : debounced button level, 1 = pressed
interface mode_button_ctrl_if;
   import led_anim_pkg::*;

   logic              btn_n;
   logic [MODE_W-1:0] mode;
   logic              mode_changed;
   logic              long_press;
   logic              btn_db;

   modport master (
      output btn_n,
      input  mode, mode_changed, long_press, btn_db
   );

   modport slave (
      input  btn_n,
      output mode, mode_changed, long_press, btn_db
   );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-level debouncer for one active-low button.
//   clk, rst : clock, asynchronous active-high reset
//   btn_n    : raw button, asynchronous to clk, may bounce
//   btn_db   : debounced level, 1 = pressed
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYC = 20,
   parameter int unsigned CNT_W        = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic btn_db
);

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [1:0]       sync_q;
   logic [CNT_W-1:0] db_cnt_q;
   logic             btn_s_c;

   // Synchroniser resets to "released" so a held button reads as a new press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], btn_n};
      end
   end

   assign btn_s_c = ~sync_q[1];

   // Accept a new level only after DEBOUNCE_CYC consecutive differing samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_q <= '0;
         btn_db   <= 1'b0;
      end else if (btn_s_c == btn_db) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_q <= '0;
         btn_db   <= btn_s_c;
      end else begin
         db_cnt_q <= db_cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mode_button_ctrl.sv
// Classifies debounced button presses into short/long and maintains the
// 2-bit animation mode for the LED top.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of mode_button_ctrl_if (btn_n in; mode,
//              mode_changed, long_press, btn_db out)
module mode_button_ctrl
   import led_anim_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 20,
   parameter int unsigned LONG_CYC     = 200,
   parameter int unsigned NUM_MODES    = 3,
   parameter int unsigned CNT_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   mode_button_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);

   btn_state_e        state_q, state_d;
   logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic [MODE_W-1:0] mode_d;
   logic              mode_changed_d;
   logic              long_press_d;
   logic              long_hit_c;
   logic              short_hit_c;

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .CNT_W        (CNT_W)
   ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (bus.btn_n),
      .btn_db (bus.btn_db)
   );

   // Long press wins when release coincides with the last hold cycle.
   assign long_hit_c  = (state_q == ST_HELD) && bus.btn_db && (hold_cnt_q == HOLD_LAST);
   assign short_hit_c = (state_q == ST_HELD) && !bus.btn_db;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.btn_db) begin
               state_d    = ST_HELD;
               hold_cnt_d = '0;
            end
         end
         ST_HELD: begin
            if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
            if (long_hit_c) begin
               state_d = ST_LONG_HELD;
            end else if (short_hit_c) begin
               state_d = ST_IDLE;
            end
         end
         ST_LONG_HELD: begin
            if (!bus.btn_db) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic: next mode and pulses, registered below
   always_comb begin
      mode_d         = bus.mode;
      mode_changed_d = 1'b0;
      long_press_d   = 1'b0;
      if (long_hit_c) begin
         mode_d         = MODE_OFF;
         mode_changed_d = 1'b1;
         long_press_d   = 1'b1;
      end else if (short_hit_c) begin
         mode_d         = next_short_mode(bus.mode, NUM_MODES);
         mode_changed_d = 1'b1;
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mode         <= MODE_SHIFT;
         bus.mode_changed <= 1'b0;
         bus.long_press   <= 1'b0;
      end else begin
         bus.mode         <= mode_d;
         bus.mode_changed <= mode_changed_d;
         bus.long_press   <= long_press_d;
      end
   end

endmodule

// File: tb/tb_mode_button_ctrl.sv
// Directed bench for mode_button_ctrl with an expected-pulse scoreboard.
module tb_mode_button_ctrl;

   localparam int unsigned DEB  = 4;
   localparam int unsigned LONG = 16;
   localparam int unsigned NMOD = 3;

   typedef struct {
      logic [1:0] mode;
      logic       lp;
   } exp_t;

   logic clk;
   logic rst;

   mode_button_ctrl_if bus();

   mode_button_ctrl #(
      .DEBOUNCE_CYC (DEB),
      .LONG_CYC     (LONG),
      .NUM_MODES    (NMOD),
      .CNT_W        (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         checks;
   int         errors;
   exp_t       exp_q[$];
   logic [1:0] cur_mode;
   logic [1:0] sched_mode;
   logic       db_prev;
   int         db_rises;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
      checks++;
      assert (got === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
      end
   endtask

   task automatic push_exp(input logic [1:0] m, input logic lp);
      exp_t e;
      e.mode = m;
      e.lp   = lp;
      exp_q.push_back(e);
   endtask

   task automatic push_short();
      if (sched_mode == 2'd3) sched_mode = 2'd0;
      else if (sched_mode == 2'(NMOD - 1)) sched_mode = 2'd0;
      else sched_mode = sched_mode + 2'd1;
      push_exp(sched_mode, 1'b0);
   endtask

   task automatic push_long();
      sched_mode = 2'd3;
      push_exp(sched_mode, 1'b1);
   endtask

   // One clock; sample 1 time unit after the edge and score any pulse.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (bus.btn_db && !db_prev) db_rises++;
      db_prev = bus.btn_db;
      if (rst) begin
         cur_mode   = 2'd0;
         sched_mode = 2'd0;
         check("rst_mode", 8'(bus.mode), 8'd0);
      end else if (bus.mode_changed) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 8'(bus.mode_changed), 8'd0);
         end else begin
            e = exp_q.pop_front();
            check("pulse_mode", 8'(bus.mode), 8'(e.mode));
            check("pulse_long", 8'(bus.long_press), 8'(e.lp));
            cur_mode = e.mode;
         end
      end else begin
         check("mode_hold", 8'(bus.mode), 8'(cur_mode));
         check("no_long", 8'(bus.long_press), 8'd0);
      end
   endtask

   // Clean press of n cycles with edge-timing checks, then release and settle.
   task automatic short_press(input int n);
      bus.btn_n = 1'b0;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (i == DEB + 1) check("db_rise_early", 8'(bus.btn_db), 8'd0);
         if (i == DEB + 2) check("db_rise", 8'(bus.btn_db), 8'd1);
      end
      bus.btn_n = 1'b1;
      push_short();
      for (int i = 1; i <= DEB + 3; i++) begin
         tick();
         if (i == DEB + 1) check("db_fall_early", 8'(bus.btn_db), 8'd1);
         if (i == DEB + 2) check("db_fall", 8'(bus.btn_db), 8'd0);
         if (i == DEB + 3) check("short_pulse", 8'(bus.mode_changed), 8'd1);
      end
      repeat (10) tick();
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      cur_mode   = 2'd0;
      sched_mode = 2'd0;
      db_prev    = 1'b0;
      db_rises   = 0;
      bus.btn_n  = 1'b1;
      rst        = 1'b1;
      repeat (3) tick();
      check("reset_db", 8'(bus.btn_db), 8'd0);
      check("reset_mc", 8'(bus.mode_changed), 8'd0);
      check("reset_lp", 8'(bus.long_press), 8'd0);
      rst = 1'b0;

      // 1: idle after reset
      repeat (50) tick();
      check("idle_mode", 8'(bus.mode), 8'd0);
      check("idle_db", 8'(bus.btn_db), 8'd0);

      // 2: three clean short presses -> 1, 2, 0
      for (int k = 0; k < 3; k++) short_press(8);
      check("wrap_mode", 8'(bus.mode), 8'd0);

      // 3: bouncy press -> one debounced rise, mode 0 -> 1
      db_rises = 0;
      for (int b = 0; b < 3; b++) begin
         bus.btn_n = 1'b0;
         tick();
         bus.btn_n = 1'b1;
         tick();
         tick();
         check("bounce_db", 8'(bus.btn_db), 8'd0);
      end
      bus.btn_n = 1'b0;
      repeat (11) tick();
      check("bounce_held_db", 8'(bus.btn_db), 8'd1);
      bus.btn_n = 1'b1;
      push_short();
      for (int i = 1; i <= DEB + 3; i++) begin
         tick();
         if (i == DEB + 3) check("bounce_pulse", 8'(bus.mode_changed), 8'd1);
      end
      repeat (10) tick();
      check("bounce_rises", 8'(db_rises), 8'd1);
      check("bounce_mode", 8'(bus.mode), 8'd1);

      // 4: long hold with a short glitch -> mode 3, silent release, then 0
      push_long();
      bus.btn_n = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         if (i == 12) bus.btn_n = 1'b1;
         if (i == 14) bus.btn_n = 1'b0;
         tick();
         if (i == DEB + 3 + LONG) begin
            check("long_lp", 8'(bus.long_press), 8'd1);
            check("long_mc", 8'(bus.mode_changed), 8'd1);
            check("long_mode", 8'(bus.mode), 8'd3);
         end
      end
      bus.btn_n = 1'b1;
      repeat (20) tick();
      check("long_release_mode", 8'(bus.mode), 8'd3);
      short_press(8);
      check("after_long_mode", 8'(bus.mode), 8'd0);

      // 5: btn_db falls on the same edge as the long decision -> long wins
      push_long();
      bus.btn_n = 1'b0;
      repeat (LONG + 1) tick();
      bus.btn_n = 1'b1;
      for (int i = LONG + 2; i <= DEB + 3 + LONG; i++) tick();
      check("race_lp", 8'(bus.long_press), 8'd1);
      check("race_db", 8'(bus.btn_db), 8'd0);
      check("race_mode", 8'(bus.mode), 8'd3);
      repeat (20) tick();

      // bring mode to 2
      for (int k = 0; k < 3; k++) short_press(8);
      check("pre_rst_mode", 8'(bus.mode), 8'd2);

      // 6: reset in HELD at hold_cnt = 10
      bus.btn_n = 1'b0;
      repeat (DEB + 3 + 10) tick();
      check("pre_rst_db", 8'(bus.btn_db), 8'd1);
      rst = 1'b1;
      #1;
      cur_mode   = 2'd0;
      sched_mode = 2'd0;
      check("rst_mid_mode", 8'(bus.mode), 8'd0);
      check("rst_mid_db", 8'(bus.btn_db), 8'd0);
      check("rst_mid_mc", 8'(bus.mode_changed), 8'd0);
      bus.btn_n = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (30) tick();
      check("post_rst_mode", 8'(bus.mode), 8'd0);

      // 7: button held through reset counts as a new press
      bus.btn_n = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      short_press(8);
      check("held_rst_mode", 8'(bus.mode), 8'd1);

      check("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
